// File: rtl/dram_cmd_sequencer_if.sv
// Request/command bus between the request scheduler (master) and the DRAM
// command sequencer (slave), including completion pulses and statistics.
interface dram_cmd_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_type;
    logic [2:0]       req_bg;
    logic [1:0]       req_ba;
    logic [15:0]      req_row;
    logic [9:0]       req_col;
    logic             cmd_valid;
    logic [2:0]       cmd_code;
    logic [2:0]       cmd_bg;
    logic [1:0]       cmd_ba;
    logic [15:0]      cmd_row;
    logic [9:0]       cmd_col;
    logic             done;
    logic             err_type;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] conf_cnt;

    modport master (
        output req_valid, req_type, req_bg, req_ba, req_row, req_col,
        input  req_ready, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col,
        input  done, err_type, hit_cnt, miss_cnt, conf_cnt
    );

    modport slave (
        input  req_valid, req_type, req_bg, req_ba, req_row, req_col,
        output req_ready, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col,
        output done, err_type, hit_cnt, miss_cnt, conf_cnt
    );
endinterface

// File: rtl/dram_cmd_sequencer.sv
// Open-page DRAM command sequencer: classifies one request at a time against
// 32 tracked banks and issues PRE/ACT/RD/WR with fixed DIMM-clock spacing.
module dram_cmd_sequencer #(
    parameter int T_RP    = 39,
    parameter int T_RCD   = 39,
    parameter int T_CL    = 40,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  dimm_clock,
    input  logic                  rst_n,
    dram_cmd_sequencer_if.slave   bus
);
    localparam int MAX_T = (T_CL > T_CWL ? T_CL : T_CWL) + T_BURST;
    localparam int CW    = ($clog2(MAX_T + 1) > 8) ? $clog2(MAX_T + 1) : 8;

    if (T_RP < 2 || T_RCD < 2 || T_CL < 2 || T_CWL < 2 || T_BURST < 2) begin : g_param_check
        $error("dram_cmd_sequencer: timing parameters must be >= 2");
    end

    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_RD  = CW'(T_CL + T_BURST - 1);
    localparam logic [CW-1:0] LD_WR  = CW'(T_CWL + T_BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_DATA
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;
    logic [4:0]       bank_q, bank_d;
    logic [15:0]      row_q, row_d;
    logic [9:0]       col_q, col_d;
    logic [31:0]      open_q, open_d;
    logic [15:0]      open_row_q [32];
    logic [15:0]      open_row_d [32];
    logic             err_q, err_d;
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d, conf_q, conf_d;

    logic        cmd_valid_c, done_c;
    logic [2:0]  cmd_code_c;
    logic [15:0] cmd_row_c;
    logic [9:0]  cmd_col_c;
    logic [4:0]  req_bank;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign req_bank = {bus.req_bg, bus.req_ba};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        type_d     = type_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        open_d     = open_q;
        open_row_d = open_row_q;
        err_d      = 1'b0;
        hit_d      = hit_q;
        miss_d     = miss_q;
        conf_d     = conf_q;
        cmd_valid_c = 1'b0;
        cmd_code_c  = 3'd0;
        cmd_row_c   = 16'd0;
        cmd_col_c   = 10'd0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    type_d = bus.req_type;
                    bank_d = req_bank;
                    row_d  = bus.req_row;
                    col_d  = bus.req_col;
                    if (bus.req_type == 2'd3) begin
                        err_d = 1'b1;
                    end else if (open_q[req_bank] && open_row_q[req_bank] == bus.req_row) begin
                        hit_d   = sat_inc(hit_q);
                        state_d = S_CAS;
                    end else if (open_q[req_bank]) begin
                        conf_d  = sat_inc(conf_q);
                        state_d = S_PRE;
                    end else begin
                        miss_d  = sat_inc(miss_q);
                        state_d = S_ACT;
                    end
                end
            end
            S_PRE: begin
                cmd_valid_c    = 1'b1;
                cmd_code_c     = 3'd4;
                open_d[bank_q] = 1'b0;
                cnt_d          = LD_RP;
                state_d        = S_WAIT_RP;
            end
            // cnt_q holds the number of cycles left until the next command
            S_WAIT_RP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_ACT;
            end
            S_ACT: begin
                cmd_valid_c        = 1'b1;
                cmd_code_c         = 3'd1;
                cmd_row_c          = row_q;
                open_d[bank_q]     = 1'b1;
                open_row_d[bank_q] = row_q;
                cnt_d              = LD_RCD;
                state_d            = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_CAS;
            end
            S_CAS: begin
                cmd_valid_c = 1'b1;
                cmd_code_c  = (type_q == 2'd1) ? 3'd3 : 3'd2;
                cmd_col_c   = col_q;
                cnt_d       = (type_q == 2'd1) ? LD_WR : LD_RD;
                state_d     = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dimm_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            open_q  <= '0;
            for (int i = 0; i < 32; i++) open_row_q[i] <= '0;
            err_q   <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
            conf_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            open_q     <= open_d;
            open_row_q <= open_row_d;
            err_q      <= err_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            conf_q     <= conf_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.cmd_valid = cmd_valid_c;
    assign bus.cmd_code  = cmd_code_c;
    assign bus.cmd_bg    = cmd_valid_c ? bank_q[4:2] : 3'd0;
    assign bus.cmd_ba    = cmd_valid_c ? bank_q[1:0] : 2'd0;
    assign bus.cmd_row   = cmd_row_c;
    assign bus.cmd_col   = cmd_col_c;
    assign bus.done      = done_c;
    assign bus.err_type  = err_q;
    assign bus.hit_cnt   = hit_q;
    assign bus.miss_cnt  = miss_q;
    assign bus.conf_cnt  = conf_q;
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: command timing, classification,
// statistics, reserved-type drop and mid-request reset.
module tb_dram_cmd_sequencer;
    logic dimm_clock = 1'b0;
    logic rst_n      = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dram_cmd_sequencer_if #(.CNT_W(16)) bus();

    dram_cmd_sequencer dut (
        .dimm_clock (dimm_clock),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 dimm_clock = ~dimm_clock;

    // Offsets are counted in cycles after the accept edge (offset 1 = A+1)
    int          r_pre, r_act, r_cas, r_done, r_ready, r_err;
    int          n_cmd, n_err, addr_bad, idle_bad, notready;
    logic [2:0]  r_cas_code;
    logic [15:0] r_act_row;
    logic [9:0]  r_cas_col;

    task automatic run_req(input logic [1:0] t, input logic [2:0] bg, input logic [1:0] ba,
                           input logic [15:0] row, input logic [9:0] col, input int limit);
        r_pre = -1; r_act = -1; r_cas = -1; r_done = -1; r_ready = -1; r_err = -1;
        n_cmd = 0; n_err = 0; addr_bad = 0; idle_bad = 0; notready = 0;
        r_cas_code = 3'd0; r_act_row = 16'd0; r_cas_col = 10'd0;
        bus.req_type = t; bus.req_bg = bg; bus.req_ba = ba;
        bus.req_row = row; bus.req_col = col; bus.req_valid = 1'b1;
        @(posedge dimm_clock);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge dimm_clock);
            if (!bus.req_ready) notready++;
            if (bus.err_type) begin n_err++; if (r_err < 0) r_err = k; end
            if (bus.cmd_valid) begin
                n_cmd++;
                if (bus.cmd_bg !== bg || bus.cmd_ba !== ba) addr_bad++;
                case (bus.cmd_code)
                    3'd4: begin
                        if (r_pre < 0) r_pre = k;
                        if (bus.cmd_row !== 16'd0 || bus.cmd_col !== 10'd0) addr_bad++;
                    end
                    3'd1: begin
                        if (r_act < 0) r_act = k;
                        r_act_row = bus.cmd_row;
                        if (bus.cmd_col !== 10'd0) addr_bad++;
                    end
                    3'd2, 3'd3: begin
                        if (r_cas < 0) r_cas = k;
                        r_cas_code = bus.cmd_code;
                        r_cas_col  = bus.cmd_col;
                        if (bus.cmd_row !== 16'd0) addr_bad++;
                    end
                    default: addr_bad++;
                endcase
            end else if (bus.cmd_code !== 3'd0 || bus.cmd_bg !== 3'd0 || bus.cmd_ba !== 2'd0 ||
                         bus.cmd_row !== 16'd0 || bus.cmd_col !== 10'd0) begin
                idle_bad++;
            end
            if (bus.done && r_done < 0) r_done = k;
            if (bus.req_ready && r_done >= 0) begin
                r_ready = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_type = 2'd0; bus.req_bg = 3'd0;
        bus.req_ba = 2'd0; bus.req_row = 16'd0; bus.req_col = 10'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge dimm_clock);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", bus.req_ready); end
        checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_code !== 3'd0) begin errors++; $display("FAIL reset_cmd: got valid=%b code=%0d, expected 0/0", bus.cmd_valid, bus.cmd_code); end
        checks++; if (bus.done !== 1'b0 || bus.err_type !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b err=%b, expected 0/0", bus.done, bus.err_type); end
        checks++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0 || bus.conf_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", bus.hit_cnt, bus.miss_cnt, bus.conf_cnt); end
        rst_n = 1'b1;
        @(negedge dimm_clock);
    endtask

    task automatic test_miss_read();
        run_req(2'd0, 3'd3, 2'd1, 16'h00AB, 10'h010, 200);
        checks++; if (r_act !== 1) begin errors++; $display("FAIL miss_act_time: got %0d, expected 1", r_act); end
        checks++; if (r_act_row !== 16'h00AB) begin errors++; $display("FAIL miss_act_row: got %h, expected 00ab", r_act_row); end
        checks++; if (r_pre !== -1) begin errors++; $display("FAIL miss_no_pre: got %0d, expected -1", r_pre); end
        checks++; if (r_cas !== 40 || r_cas_code !== 3'd2) begin errors++; $display("FAIL miss_rd: got t=%0d code=%0d, expected 40/2", r_cas, r_cas_code); end
        checks++; if (r_cas_col !== 10'h010) begin errors++; $display("FAIL miss_rd_col: got %h, expected 010", r_cas_col); end
        checks++; if (r_done !== 88 || r_ready !== 89) begin errors++; $display("FAIL miss_done: got done=%0d ready=%0d, expected 88/89", r_done, r_ready); end
        checks++; if (bus.miss_cnt !== 16'd1 || bus.hit_cnt !== 16'd0 || bus.conf_cnt !== 16'd0) begin errors++; $display("FAIL miss_counters: got h=%0d m=%0d c=%0d, expected 0/1/0", bus.hit_cnt, bus.miss_cnt, bus.conf_cnt); end
        checks++; if (addr_bad !== 0 || idle_bad !== 0) begin errors++; $display("FAIL miss_addr_outputs: got bad=%0d idle_bad=%0d, expected 0/0", addr_bad, idle_bad); end
    endtask

    task automatic test_hit_write();
        run_req(2'd1, 3'd3, 2'd1, 16'h00AB, 10'h020, 200);
        checks++; if (r_cas !== 1 || r_cas_code !== 3'd3) begin errors++; $display("FAIL hit_wr: got t=%0d code=%0d, expected 1/3", r_cas, r_cas_code); end
        checks++; if (n_cmd !== 1 || r_act !== -1 || r_pre !== -1) begin errors++; $display("FAIL hit_cmds: got n=%0d act=%0d pre=%0d, expected 1/-1/-1", n_cmd, r_act, r_pre); end
        checks++; if (r_done !== 47 || r_ready !== 48) begin errors++; $display("FAIL hit_done: got done=%0d ready=%0d, expected 47/48", r_done, r_ready); end
        checks++; if (bus.hit_cnt !== 16'd1 || bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL hit_counters: got h=%0d m=%0d, expected 1/1", bus.hit_cnt, bus.miss_cnt); end
    endtask

    task automatic test_conflict();
        run_req(2'd2, 3'd3, 2'd1, 16'h00AC, 10'h030, 250);
        checks++; if (r_pre !== 1 || r_act !== 40 || r_cas !== 79) begin errors++; $display("FAIL conf_times: got pre=%0d act=%0d rd=%0d, expected 1/40/79", r_pre, r_act, r_cas); end
        checks++; if (r_act_row !== 16'h00AC || r_cas_code !== 3'd2) begin errors++; $display("FAIL conf_act_row_code: got row=%h code=%0d, expected 00ac/2", r_act_row, r_cas_code); end
        checks++; if (r_done !== 127 || r_ready !== 128) begin errors++; $display("FAIL conf_done: got done=%0d ready=%0d, expected 127/128", r_done, r_ready); end
        checks++; if (bus.conf_cnt !== 16'd1 || bus.hit_cnt !== 16'd1 || bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL conf_counters: got h=%0d m=%0d c=%0d, expected 1/1/1", bus.hit_cnt, bus.miss_cnt, bus.conf_cnt); end
        checks++; if (addr_bad !== 0 || idle_bad !== 0) begin errors++; $display("FAIL conf_addr_outputs: got bad=%0d idle_bad=%0d, expected 0/0", addr_bad, idle_bad); end
    endtask

    task automatic test_other_bank();
        run_req(2'd0, 3'd0, 2'd0, 16'h0055, 10'h005, 200);
        checks++; if (r_act !== 1 || r_pre !== -1 || r_act_row !== 16'h0055) begin errors++; $display("FAIL other_miss: got act=%0d pre=%0d row=%h, expected 1/-1/0055", r_act, r_pre, r_act_row); end
        checks++; if (bus.miss_cnt !== 16'd2) begin errors++; $display("FAIL other_miss_cnt: got %0d, expected 2", bus.miss_cnt); end
        run_req(2'd0, 3'd3, 2'd1, 16'h00AC, 10'h007, 200);
        checks++; if (r_cas !== 1 || r_act !== -1 || r_pre !== -1) begin errors++; $display("FAIL kept_row_hit: got rd=%0d act=%0d pre=%0d, expected 1/-1/-1", r_cas, r_act, r_pre); end
        checks++; if (r_done !== 49 || bus.hit_cnt !== 16'd2) begin errors++; $display("FAIL kept_row_done: got done=%0d hits=%0d, expected 49/2", r_done, bus.hit_cnt); end
    endtask

    task automatic test_reserved();
        run_req(2'd3, 3'd1, 2'd1, 16'h0099, 10'h001, 6);
        checks++; if (r_err !== 1 || n_err !== 1) begin errors++; $display("FAIL rsv_err_pulse: got t=%0d n=%0d, expected 1/1", r_err, n_err); end
        checks++; if (n_cmd !== 0 || r_done !== -1) begin errors++; $display("FAIL rsv_no_cmd: got cmds=%0d done=%0d, expected 0/-1", n_cmd, r_done); end
        checks++; if (notready !== 0) begin errors++; $display("FAIL rsv_ready: got %0d not-ready cycles, expected 0", notready); end
        checks++; if (bus.hit_cnt !== 16'd2 || bus.miss_cnt !== 16'd2 || bus.conf_cnt !== 16'd1) begin errors++; $display("FAIL rsv_counters: got h=%0d m=%0d c=%0d, expected 2/2/1", bus.hit_cnt, bus.miss_cnt, bus.conf_cnt); end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        bus.req_type = 2'd0; bus.req_bg = 3'd5; bus.req_ba = 2'd2;
        bus.req_row = 16'h1234; bus.req_col = 10'h008; bus.req_valid = 1'b1;
        @(posedge dimm_clock);
        #1 bus.req_valid = 1'b0;
        repeat (5) @(negedge dimm_clock);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got ready=%b valid=%b done=%b, expected 1/0/0", bus.req_ready, bus.cmd_valid, bus.done); end
        checks++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0 || bus.conf_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_counters: got %0d/%0d/%0d, expected 0/0/0", bus.hit_cnt, bus.miss_cnt, bus.conf_cnt); end
        repeat (2) @(negedge dimm_clock);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge dimm_clock);
            if (bus.cmd_valid || bus.done) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_abandon: got %0d stray cycles, expected 0", stray); end
        run_req(2'd0, 3'd5, 2'd2, 16'h1234, 10'h008, 200);
        checks++; if (r_act !== 1 || r_pre !== -1 || bus.miss_cnt !== 16'd1 || bus.hit_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_reclass: got act=%0d pre=%0d miss=%0d hit=%0d, expected 1/-1/1/0", r_act, r_pre, bus.miss_cnt, bus.hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_miss_read();
        test_hit_write();
        test_conflict();
        test_other_bank();
        test_reserved();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
- Downstream of the trace-driven request scheduler.
- Consumes one decoded request at a time (type, bank group, bank, row, column) from the scheduler's queue head.
- Tracks open rows for all 32 banks (8 BG x 4 BA) under an open-page policy.
- Issues timed PRE/ACT/RD/WR commands on the DIMM clock, with hit/miss/conflict statistics.

Parameters:
- T_RP, 39, dimm_clock cycles from PRE to ACT on the same bank
- T_RCD, 39, dimm_clock cycles from ACT to RD/WR
- T_CL, 40, read latency in dimm_clock cycles from RD to the first data beat
- T_CWL, 38, write latency in dimm_clock cycles from WR to the first data beat
- T_BURST, 8, dimm_clock cycles of data transfer (BL16)
- CNT_W, 16, width of the statistics counters

Ports:
- dimm_clock  in  1  DIMM command clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present at queue head
- req_ready  out  1  sequencer can accept a request
- req_type  in  2  0 = data read, 1 = data write, 2 = instruction fetch (treated as read), 3 = reserved
- req_bg  in  3  bank group
- req_ba  in  2  bank
- req_row  in  16  row
- req_col  in  10  column
- cmd_valid  out  1  one-cycle command strobe
- cmd_code  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_bg  out  3  command bank group
- cmd_ba  out  2  command bank
- cmd_row  out  16  row (valid on ACT, otherwise 0)
- cmd_col  out  10  column (valid on RD/WR, otherwise 0)
- done  out  1  one-cycle pulse when the request's data burst completes
- err_type  out  1  one-cycle pulse when a reserved type is dropped
- hit_cnt  out  CNT_W  row-hit count
- miss_cnt  out  CNT_W  closed-bank count
- conf_cnt  out  CNT_W  row-conflict count

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; all bank-open bits clear; open-row registers are 0.
  - req_ready=1, cmd_valid=0, cmd_code=0, cmd_bg/ba/row/col=0, done=0, err_type=0, all counters 0.
  - Reset mid-request abandons it; no command or done is emitted afterwards.
- Handshake: a transfer occurs on a dimm_clock edge with req_valid & req_ready. req_ready=1 only in IDLE, so at most one request is outstanding. The request fields are latched at the transfer.
- Reserved type 3: accepted, err_type pulses the next cycle, no command, no counter change, FSM stays in IDLE.
- Classification at acceptance (bank index = {bg, ba}):
  - Hit: bank open and row matches; hit_cnt+1; first command is RD/WR.
  - Miss: bank closed; miss_cnt+1; first command is ACT.
  - Conflict: bank open with a different row; conf_cnt+1; first command is PRE.
  - All counters saturate at all-ones.
- FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_DATA.
  - IDLE goes to PRE / ACT / CAS per classification; the first command is driven in cycle A+1, where A is the accept edge.
  - PRE: cmd_valid=1, code 4; clears the bank's open bit; then WAIT_RP.
  - ACT is issued exactly T_RP cycles after PRE.
  - ACT: code 4→1 path; cmd_row=row; sets the open bit and stores the row; then WAIT_RCD.
  - CAS is issued exactly T_RCD cycles after ACT.
  - CAS: code 2 for types 0/2, code 3 for type 1; cmd_col=col; then WAIT_DATA.
  - done pulses exactly T_CL+T_BURST (read) or T_CWL+T_BURST (write) cycles after CAS. The FSM is in IDLE on the following cycle, so req_ready rises one cycle after done.
- A single down-counter (8-bit minimum) times all waits. It is loaded with the parameter value minus 1 on the issuing cycle.
- cmd_valid is low in every non-command cycle, with cmd_code=0 and the address outputs at 0.
- The bank stays open after CAS (open page). Rows in other banks are unaffected.
- Parameters of value 0 or 1 are illegal; elaboration errors if any timing parameter is < 2.

Test Plan:
- Reset, then read type 0, bg=3, ba=1, row=0x00AB, col=0x010, accepted at edge 10 -> ACT at 11 (row 0xAB), RD at 50 (col 0x10), done at 98, req_ready high at 99; miss_cnt=1.
- Same bank/row, type 1 write after the first -> WR one cycle after accept, done 46 cycles later; hit_cnt=1, no ACT/PRE.
- Same bank, row 0x00AC, type 2 -> PRE at A+1, ACT at A+40, RD at A+79; conf_cnt=1; ACT row=0xAC.
- Different bank (bg=0, ba=0) after the above -> ACT issued (miss) while bank {3,1} keeps row 0xAC: a following row-0xAC read to {3,1} is a hit.
- req_type=3 -> err_type pulse, no cmd_valid for 5 cycles, counters unchanged, req_ready stays 1.
- rst_n low during WAIT_RCD -> all outputs at reset values immediately; after release, a request to the previously activated bank is classified as a miss.
